// File: rtl/ast_systolic_operand_feeder_pkg.sv
// Shared defaults, write-select encoding and effective-K helper for the
// systolic operand feeder.
package ast_systolic_operand_feeder_pkg;

  localparam int unsigned SIZE_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // k == 0 or k > size both mean "full inner dimension".
  function automatic int unsigned calc_keff(input int unsigned k, input int unsigned size);
    return (k == 0 || k > size) ? size : k;
  endfunction

endpackage

// File: rtl/ast_systolic_operand_feeder_bank.sv
// One SIZE x SIZE operand store with valid bitmap, write port and a
// registered skew-read lane mux.
module ast_operand_bank #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter bit          TRANSPOSE = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      we_i,
  input  logic [$clog2(SIZE)-1:0]   row_i,
  input  logic [$clog2(SIZE)-1:0]   col_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(SIZE):0]     keff_i,
  input  logic [SIZE:0]             t_i,
  output logic [SIZE*DATA_W-1:0]    lanes_o,
  output logic [SIZE*SIZE-1:0]      valid_d_o
);

  localparam int unsigned IW = $clog2(SIZE);
  localparam int unsigned TW = SIZE + 2;

  logic [DATA_W-1:0]      mem_q [SIZE][SIZE];
  logic [SIZE*SIZE-1:0]   valid_q, valid_d;
  logic [SIZE*DATA_W-1:0] lanes_q, lanes_d;
  logic [TW-1:0]          t_ext, diag;
  logic [IW-1:0]          idx;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[row_i][col_i] <= data_i;
  end

  always_comb begin
    valid_d = valid_q;
    if (clear_i)   valid_d = '0;
    else if (we_i) valid_d[32'(row_i) * SIZE + 32'(col_i)] = 1'b1;
  end

  // Lane l reads diagonal offset t-l; TRANSPOSE swaps which index is the lane.
  always_comb begin
    lanes_d = '0;
    t_ext   = TW'(t_i);
    diag    = '0;
    idx     = '0;
    for (int unsigned l = 0; l < SIZE; l++) begin
      if (TW'(l) <= t_ext) begin
        diag = t_ext - TW'(l);
        if (diag < TW'(keff_i)) begin
          idx = diag[IW-1:0];
          lanes_d[l*DATA_W +: DATA_W] = TRANSPOSE ? mem_q[idx][IW'(l)] : mem_q[IW'(l)][idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      lanes_q <= '0;
    end else begin
      valid_q <= valid_d;
      lanes_q <= lanes_d;
    end
  end

  assign lanes_o   = lanes_q;
  assign valid_d_o = valid_d;

endmodule

// File: rtl/ast_systolic_operand_feeder.sv
// Operand-side responder: stores host-written A/B matrices and drives skewed
// wavefronts into the systolic array edges.
module ast_systolic_operand_feeder
  import ast_systolic_operand_feeder_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(SIZE)-1:0]   wr_row,
  input  logic [$clog2(SIZE)-1:0]   wr_col,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      clear,
  input  logic [$clog2(SIZE):0]     k_dim,
  input  logic                      busy,
  input  logic [SIZE:0]             memsel_A,
  input  logic [SIZE:0]             memsel_B,
  output logic [SIZE*DATA_W-1:0]    a_out,
  output logic [SIZE*DATA_W-1:0]    b_out,
  output logic                      operands_ready,
  output logic                      wr_err
);

  localparam int unsigned KW = $clog2(SIZE) + 1;

  logic [KW-1:0]        keff;
  logic                 wr_ok, we_a, we_b;
  logic [SIZE*SIZE-1:0] va_d, vb_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;

  assign keff  = KW'(calc_keff(32'(k_dim), SIZE));
  assign wr_ok = wr_en && !busy && !clear && !reset;
  assign we_a  = wr_ok && (sel_e'(wr_sel) == SEL_A);
  assign we_b  = wr_ok && (sel_e'(wr_sel) == SEL_B);
  assign err_d = wr_en && busy && !clear;

  ast_operand_bank #(.SIZE(SIZE), .DATA_W(DATA_W), .TRANSPOSE(1'b0)) u_bank_a (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (clear),
    .we_i      (we_a),
    .row_i     (wr_row),
    .col_i     (wr_col),
    .data_i    (wr_data),
    .keff_i    (keff),
    .t_i       (memsel_A),
    .lanes_o   (a_out),
    .valid_d_o (va_d)
  );

  ast_operand_bank #(.SIZE(SIZE), .DATA_W(DATA_W), .TRANSPOSE(1'b1)) u_bank_b (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (clear),
    .we_i      (we_b),
    .row_i     (wr_row),
    .col_i     (wr_col),
    .data_i    (wr_data),
    .keff_i    (keff),
    .t_i       (memsel_B),
    .lanes_o   (b_out),
    .valid_d_o (vb_d)
  );

  // Built from next-state bitmaps so readiness trails the last write by one cycle.
  always_comb begin
    ready_d = 1'b1;
    for (int unsigned r = 0; r < SIZE; r++) begin
      for (int unsigned c = 0; c < SIZE; c++) begin
        if (c < 32'(keff) && !va_d[r*SIZE + c]) ready_d = 1'b0;
        if (r < 32'(keff) && !vb_d[r*SIZE + c]) ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign operands_ready = ready_q;
  assign wr_err         = err_q;

endmodule

// File: tb/tb_ast_systolic_operand_feeder.sv
// Self-checking bench: matrix-level reference model plus directed scenarios
// and a randomized phase.
module tb_ast_systolic_operand_feeder;

  localparam int SIZE = 4;
  localparam int DW   = 8;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_sel, clear, busy;
  logic [1:0]  wr_row, wr_col;
  logic [7:0]  wr_data;
  logic [2:0]  k_dim;
  logic [4:0]  memsel_A, memsel_B;
  logic [31:0] a_out, b_out;
  logic        operands_ready, wr_err;

  always #5 clk = ~clk;

  ast_systolic_operand_feeder #(.SIZE(SIZE), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .clear(clear),
    .k_dim(k_dim), .busy(busy), .memsel_A(memsel_A), .memsel_B(memsel_B),
    .a_out(a_out), .b_out(b_out), .operands_ready(operands_ready), .wr_err(wr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (matrix view) ----------------
  logic [7:0]  mA[4][4], mB[4][4];
  bit          vA[4][4], vB[4][4];
  bit          kA[4][4], kB[4][4];   // entry ever written (data known)
  logic [31:0] exp_a, exp_b, msk_a, msk_b;
  logic        exp_rdy, exp_err;
  bit          model_live = 0;

  function automatic int keff_of(input int k);
    return (k == 0 || k > SIZE) ? SIZE : k;
  endfunction

  always @(posedge clk) begin
    int ke, ta, tb;
    bit rdy;
    if (reset) begin
      exp_a = '0; exp_b = '0; msk_a = '1; msk_b = '1;
      exp_rdy = 0; exp_err = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin vA[r][c] = 0; vB[r][c] = 0; end
      model_live = 1;
    end else begin
      ke = keff_of(int'(k_dim));
      ta = int'(memsel_A);
      tb = int'(memsel_B);
      exp_a = '0; exp_b = '0; msk_a = '1; msk_b = '1;
      for (int i = 0; i < 4; i++) begin
        if (i <= ta && ta - i < ke) begin
          exp_a[i*8 +: 8] = mA[i][ta-i];
          if (!kA[i][ta-i]) msk_a[i*8 +: 8] = 8'h00;
        end
        if (i <= tb && tb - i < ke) begin
          exp_b[i*8 +: 8] = mB[tb-i][i];
          if (!kB[tb-i][i]) msk_b[i*8 +: 8] = 8'h00;
        end
      end
      exp_err = wr_en && busy && !clear;
      if (clear) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin vA[r][c] = 0; vB[r][c] = 0; end
      end else if (wr_en && !busy) begin
        if (wr_sel) begin
          mB[wr_row][wr_col] = wr_data; vB[wr_row][wr_col] = 1; kB[wr_row][wr_col] = 1;
        end else begin
          mA[wr_row][wr_col] = wr_data; vA[wr_row][wr_col] = 1; kA[wr_row][wr_col] = 1;
        end
      end
      rdy = 1;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (c < ke && !vA[r][c]) rdy = 0;
          if (r < ke && !vB[r][c]) rdy = 0;
        end
      exp_rdy = rdy;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_a_out", a_out & msk_a, exp_a & msk_a);
      chk("model_b_out", b_out & msk_b, exp_b & msk_b);
      chk("model_ready", {31'b0, operands_ready}, {31'b0, exp_rdy});
      chk("model_wr_err", {31'b0, wr_err}, {31'b0, exp_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int r, input int c, input logic [7:0] d);
    wr_en = 1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 0;
    clear = 0; k_dim = 3'd4; busy = 0; memsel_A = 0; memsel_B = 0;
    tick(); tick();
    reset = 0;
    chk("rst_a_out", a_out, 32'h0);
    chk("rst_b_out", b_out, 32'h0);
    chk("rst_ready", {31'b0, operands_ready}, 32'h0);
    chk("rst_wr_err", {31'b0, wr_err}, 32'h0);

    // Test 1: identity A, B[r][c] = r*4+c, full K
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
        wr(1'b1, r, c, 8'(r*4 + c));
      end
    chk("t1_ready", {31'b0, operands_ready}, 32'h1);
    busy = 1;
    for (int t = 0; t < 8; t++) begin
      memsel_A = 5'(t); memsel_B = 5'(t);
      tick();
      if (t == 0) begin
        chk("t1_a_t0", a_out, 32'h0000_0001);
        chk("t1_b_t0", b_out, 32'h0000_0000);
      end
      if (t == 3) begin
        chk("t1_a_t3", a_out, 32'h0000_0000);
        chk("t1_b_t3", b_out, {8'd3, 8'd6, 8'd9, 8'd12});
      end
      if (t == 6) begin
        chk("t1_a_t6", a_out, 32'h0100_0000);
        chk("t1_b_t6", b_out, 32'h0F00_0000);
      end
      if (t == 7) begin
        chk("t1_a_t7", a_out, 32'h0);
        chk("t1_b_t7", b_out, 32'h0);
      end
      tick();
    end
    busy = 0; memsel_A = 0; memsel_B = 0;

    // Test 2: readiness only after the final missing entry
    do_clear();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r, c, 8'(16*r + c + 1));
        if (!(r == 3 && c == 2)) wr(1'b1, r, c, 8'(8'h80 + 16*r + c));
      end
    chk("t2_not_ready", {31'b0, operands_ready}, 32'h0);
    wr(1'b1, 3, 2, 8'd5);
    chk("t2_ready", {31'b0, operands_ready}, 32'h1);

    // Test 3: k_dim = 2, partial fill
    do_clear();
    k_dim = 3'd2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) wr(1'b0, r, c, 8'(16*r + c + 1));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) wr(1'b1, r, c, 8'(8'h80 + 16*r + c));
    chk("t3_ready", {31'b0, operands_ready}, 32'h1);
    memsel_A = 5'd2; memsel_B = 5'd2;
    tick();
    chk("t3_a_lane0", {24'b0, a_out[7:0]}, 32'h0);
    chk("t3_a_lane1", {24'b0, a_out[15:8]}, 32'h12);
    chk("t3_a_t2", a_out, 32'h0021_1200);

    // Test 4: write while busy is rejected
    memsel_A = 0; memsel_B = 0;
    busy = 1;
    wr(1'b0, 0, 0, 8'hAA);
    chk("t4_err_pulse", {31'b0, wr_err}, 32'h1);
    tick();
    chk("t4_err_drop", {31'b0, wr_err}, 32'h0);
    busy = 0;
    tick();
    chk("t4_a00_kept", {24'b0, a_out[7:0]}, 32'h01);

    // Test 5: clear wins over a simultaneous write
    clear = 1;
    wr(1'b0, 0, 0, 8'h77);
    clear = 0;
    chk("t5_ready", {31'b0, operands_ready}, 32'h0);
    chk("t5_no_err", {31'b0, wr_err}, 32'h0);
    tick();
    chk("t5_a00_kept", {24'b0, a_out[7:0]}, 32'h01);

    // Test 6: reset mid-sequence
    k_dim = 3'd4;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r, c, 8'(16*r + c + 1));
        wr(1'b1, r, c, 8'(8'h80 + 16*r + c));
      end
    chk("t6_ready_pre", {31'b0, operands_ready}, 32'h1);
    busy = 1;
    for (int t = 0; t < 4; t++) begin
      memsel_A = 5'(t); memsel_B = 5'(t);
      tick(); tick();
    end
    chk("t6_b_t3", b_out, {8'h83, 8'h92, 8'hA1, 8'hB0});
    reset = 1;
    tick();
    chk("t6_rst_a", a_out, 32'h0);
    chk("t6_rst_b", b_out, 32'h0);
    chk("t6_rst_ready", {31'b0, operands_ready}, 32'h0);
    reset = 0; busy = 0; memsel_A = 0; memsel_B = 0;
    tick();
    chk("t6_invalid", {31'b0, operands_ready}, 32'h0);
    wr(1'b0, 0, 0, 8'h11);
    chk("t6_one_entry", {31'b0, operands_ready}, 32'h0);

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_sel  = 1'($urandom_range(0, 1));
      wr_row  = 2'($urandom_range(0, 3));
      wr_col  = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      clear   = ($urandom_range(0, 63) == 0);
      busy    = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) k_dim = 3'($urandom_range(0, 7));
      if (n % 2 == 0) begin
        memsel_A = 5'($urandom_range(0, 31));
        memsel_B = ($urandom_range(0, 1) == 0) ? memsel_A : 5'($urandom_range(0, 31));
      end
      tick();
    end
    wr_en = 0; clear = 0; busy = 0; reset = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
